medidor_periodo_param: RTL and testbench

- Parametrised successor of the single-signal period counter: measures the period, high time and low time of an asynchronous input `sinal`, counted in clocks.
- Also reports the period scaled to time units, a one-cycle valid strobe per measurement, and a sticky overflow flag.
- Sits between an external slow digital input and downstream display/logging logic.

---
 rtl/medidor_periodo_param.sv | 179 +++++++++++++++++
 tb/tb_medidor_periodo_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_periodo_param.sv
// Measures period, high time and low time of an asynchronous input, in clock cycles.
// Latency: edges seen SYNC_STAGES+1 cycles after the input; results registered on the closing rise.
// Backpressure: none; valido is a one-cycle strobe and results hold until the next one.
module medidor_periodo_param #(
    parameter int WIDTH       = 12,
    parameter int TW          = 16,
    parameter int CLK_PERIOD  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sinal,
    input  logic             enable,
    input  logic             estouro_clr,
    output logic [WIDTH-1:0] quant_clocks,
    output logic [WIDTH-1:0] tempo_alto,
    output logic [WIDTH-1:0] tempo_baixo,
    output logic [TW-1:0]    tempocontado,
    output logic             valido,
    output logic             estouro
);

    localparam int PW = WIDTH + 8;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    typedef enum logic [1:0] {
        ESPERA,
        ALTO,
        BAIXO
    } estado_t;

    estado_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;

    logic [WIDTH-1:0] cnt_per, cnt_alto, cnt_baixo, hold_alto;
    logic [WIDTH-1:0] per_d, alto_d, baixo_d, hold_d;
    logic             publish;
    logic             sat_evt;

    logic [PW-1:0] prod;
    logic [TW-1:0] scaled;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // True when this increment is the one that lands on the maximum.
    function automatic logic hits_max(input logic [WIDTH-1:0] v);
        return v == CNT_NEAR;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sinal};
            s_prev <= s_sync;
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;
    assign fall   = ~s_sync & s_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ESPERA;
            cnt_per   <= '0;
            cnt_alto  <= '0;
            cnt_baixo <= '0;
            hold_alto <= '0;
        end else begin
            state_q   <= state_d;
            cnt_per   <= per_d;
            cnt_alto  <= alto_d;
            cnt_baixo <= baixo_d;
            hold_alto <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = cnt_per;
        alto_d  = cnt_alto;
        baixo_d = cnt_baixo;
        hold_d  = hold_alto;
        publish = 1'b0;
        sat_evt = 1'b0;
        if (!enable) begin
            state_d = ESPERA;
            per_d   = '0;
            alto_d  = '0;
            baixo_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ESPERA: begin
                    // The partial period before the first rise is discarded.
                    if (rise) begin
                        state_d = ALTO;
                        per_d   = CNT_ONE;
                        alto_d  = CNT_ONE;
                    end
                end
                ALTO: begin
                    if (fall) begin
                        state_d = BAIXO;
                        hold_d  = cnt_alto;
                        per_d   = sat_inc(cnt_per);
                        baixo_d = CNT_ONE;
                        sat_evt = hits_max(cnt_per);
                    end else begin
                        per_d   = sat_inc(cnt_per);
                        alto_d  = sat_inc(cnt_alto);
                        sat_evt = hits_max(cnt_per) | hits_max(cnt_alto);
                    end
                end
                BAIXO: begin
                    if (rise) begin
                        publish = 1'b1;
                        state_d = ALTO;
                        per_d   = CNT_ONE;
                        alto_d  = CNT_ONE;
                    end else begin
                        per_d   = sat_inc(cnt_per);
                        baixo_d = sat_inc(cnt_baixo);
                        sat_evt = hits_max(cnt_per) | hits_max(cnt_baixo);
                    end
                end
                default: state_d = ESPERA;
            endcase
        end
    end

    assign prod = PW'(cnt_per) * PW'(CLK_PERIOD);

    generate
        if (TW < PW) begin : g_clamp
            localparam logic [PW-1:0] T_MAX = PW'({TW{1'b1}});
            assign scaled = (prod > T_MAX) ? {TW{1'b1}} : prod[TW-1:0];
        end else begin : g_wide
            assign scaled = TW'(prod);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quant_clocks <= '0;
            tempo_alto   <= '0;
            tempo_baixo  <= '0;
            tempocontado <= '0;
            valido       <= 1'b0;
            estouro      <= 1'b0;
        end else begin
            valido <= publish;
            if (publish) begin
                quant_clocks <= cnt_per;
                tempo_alto   <= hold_alto;
                tempo_baixo  <= cnt_baixo;
                tempocontado <= scaled;
            end
            // A new saturation outranks a simultaneous clear.
            if (sat_evt) begin
                estouro <= 1'b1;
            end else if (estouro_clr) begin
                estouro <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_medidor_periodo_param.sv
// Bench for medidor_periodo_param: timestamp-based reference model plus literal spot checks.
module tb_medidor_periodo_param;

    localparam int WIDTH = 12;
    localparam int TW    = 16;
    localparam int TW_B  = 12;
    localparam int CP    = 10;
    localparam int NS    = 2;
    localparam longint MAXC   = (64'd1 << WIDTH) - 1;
    localparam longint TMAX   = (64'd1 << TW) - 1;
    localparam longint TMAX_B = (64'd1 << TW_B) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sinal = 1'b0;
    logic enable = 1'b1;
    logic estouro_clr = 1'b0;

    logic [WIDTH-1:0] quant_clocks, tempo_alto, tempo_baixo;
    logic [TW-1:0]    tempocontado;
    logic             valido, estouro;
    logic [WIDTH-1:0] qc_b, ta_b, tb_b;
    logic [TW_B-1:0]  tc_b;
    logic             valido_b, estouro_b;

    medidor_periodo_param #(.WIDTH(WIDTH), .TW(TW), .CLK_PERIOD(CP), .SYNC_STAGES(NS)) dut (
        .clock(clock), .reset(reset), .sinal(sinal), .enable(enable),
        .quant_clocks(quant_clocks), .tempo_alto(tempo_alto), .tempo_baixo(tempo_baixo),
        .tempocontado(tempocontado), .valido(valido), .estouro(estouro),
        .estouro_clr(estouro_clr)
    );

    medidor_periodo_param #(.WIDTH(WIDTH), .TW(TW_B), .CLK_PERIOD(CP), .SYNC_STAGES(NS)) dut_b (
        .clock(clock), .reset(reset), .sinal(sinal), .enable(enable),
        .quant_clocks(qc_b), .tempo_alto(ta_b), .tempo_baixo(tb_b),
        .tempocontado(tc_b), .valido(valido_b), .estouro(estouro_b),
        .estouro_clr(estouro_clr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int vcount   = 0;
    int est_cnt  = 0;
    bit chk_on   = 1'b0;

    // Reference model state: timestamps of the last counted rise and fall.
    longint cyc = 0;
    longint r_t = 0;
    longint f_t = 0;
    bit     have_rise = 1'b0;
    bit     have_fall = 1'b0;
    bit     hist[$];
    longint exp_q = 0, exp_ta = 0, exp_tb = 0, exp_tc = 0, exp_tc_b = 0;
    bit     exp_v = 1'b0, exp_est = 1'b0;

    function automatic longint clampv(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clock or posedge reset) begin : model
        bit d, dp, rise, fall, set_ev;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < NS + 2; i++) hist.push_back(1'b0);
            cyc = 0; have_rise = 0; have_fall = 0;
            exp_q = 0; exp_ta = 0; exp_tb = 0; exp_tc = 0; exp_tc_b = 0;
            exp_v = 0; exp_est = 0;
        end else begin
            cyc++;
            hist.push_front(sinal);
            void'(hist.pop_back());
            d    = hist[NS];
            dp   = hist[NS + 1];
            rise = d & ~dp;
            fall = ~d & dp;
            exp_v  = 1'b0;
            set_ev = 1'b0;
            if (!enable) begin
                have_rise = 0;
                have_fall = 0;
            end else begin
                if (have_rise && !have_fall && (cyc - r_t == MAXC - 1)) set_ev = 1'b1;
                if (have_rise && have_fall && !rise &&
                    ((cyc - r_t == MAXC - 1) || (cyc - f_t == MAXC - 1))) set_ev = 1'b1;
                if (rise) begin
                    if (have_rise && have_fall) begin
                        exp_v    = 1'b1;
                        exp_q    = clampv(cyc - r_t, MAXC);
                        exp_ta   = clampv(f_t - r_t, MAXC);
                        exp_tb   = clampv(cyc - f_t, MAXC);
                        exp_tc   = clampv(exp_q * CP, TMAX);
                        exp_tc_b = clampv(exp_q * CP, TMAX_B);
                    end
                    r_t = cyc;
                    have_rise = 1'b1;
                    have_fall = 1'b0;
                end else if (fall && have_rise && !have_fall) begin
                    f_t = cyc;
                    have_fall = 1'b1;
                end
            end
            exp_est = set_ev ? 1'b1 : (estouro_clr ? 1'b0 : exp_est);
        end
    end

    always @(negedge clock) begin
        if (chk_on && !reset) begin
            chk("valido", valido, exp_v);
            chk("quant_clocks", quant_clocks, exp_q);
            chk("tempo_alto", tempo_alto, exp_ta);
            chk("tempo_baixo", tempo_baixo, exp_tb);
            chk("tempocontado", tempocontado, exp_tc);
            chk("estouro", estouro, exp_est);
            chk("b_valido", valido_b, exp_v);
            chk("b_quant_clocks", qc_b, exp_q);
            chk("b_tempo_alto", ta_b, exp_ta);
            chk("b_tempo_baixo", tb_b, exp_tb);
            chk("b_tempocontado", tc_b, exp_tc_b);
            chk("b_estouro", estouro_b, exp_est);
            if (valido) vcount++;
            if (estouro) est_cnt++;
        end
    end

    task automatic run_seg(input logic v, input int n);
        sinal = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic period_3_4(input int n);
        for (int i = 0; i < n; i++) begin
            run_seg(1'b1, 3);
            run_seg(1'b0, 4);
        end
    endtask

    task automatic check_outputs(input string tag, input longint q, input longint ta,
                                 input longint tb, input longint tc, input longint tcb);
        chk({tag, "_quant"}, quant_clocks, q);
        chk({tag, "_alto"}, tempo_alto, ta);
        chk({tag, "_baixo"}, tempo_baixo, tb);
        chk({tag, "_tempo"}, tempocontado, tc);
        chk({tag, "_tempo_b"}, tc_b, tcb);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_outputs("rst", 0, 0, 0, 0, 0);
        chk("rst_valido", valido, 0);
        chk("rst_estouro", estouro, 0);
        chk_on = 1'b1;

        // Periodic 3 high / 4 low: first rise unreported, then 7 strobes.
        vcount = 0;
        period_3_4(8);
        #1;
        check_outputs("pat", 7, 3, 4, 70, 70);
        chk("pat_estouro", estouro, 0);
        chk("pat_vcount", vcount, 7);

        // Asynchronous reset during the high phase.
        sinal = 1'b1;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_outputs("arst", 0, 0, 0, 0, 0);
        chk("arst_valido", valido, 0);
        @(negedge clock);
        reset = 1'b0;
        vcount = 0;
        run_seg(1'b0, 4);
        period_3_4(3);
        #1;
        chk("arst_vcount", vcount, 2);

        // Enable dropped for 20 cycles during the low phase.
        period_3_4(2);
        run_seg(1'b1, 3);
        run_seg(1'b0, 2);
        enable = 1'b0;
        #1 vcount = 0;
        run_seg(1'b0, 2);
        run_seg(1'b1, 3);
        run_seg(1'b0, 4);
        run_seg(1'b1, 3);
        run_seg(1'b0, 4);
        run_seg(1'b1, 3);
        run_seg(1'b0, 1);
        #1;
        chk("dis_vcount", vcount, 0);
        check_outputs("dis_hold", 7, 3, 4, 70, 70);
        enable = 1'b1;
        run_seg(1'b0, 3);
        period_3_4(3);
        #1;
        chk("reen_vcount", vcount, 2);

        // Randomised segments with occasional enable drops and clears.
        for (int i = 0; i < 300; i++) begin
            if (!enable) begin
                if ($urandom_range(0, 2) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                enable = 1'b0;
            end
            estouro_clr = ($urandom_range(0, 29) == 0);
            run_seg(~sinal, $urandom_range(1, 20));
        end
        estouro_clr = 1'b0;
        enable = 1'b1;
        period_3_4(2);

        // Clear, then a long low phase that saturates the counters.
        estouro_clr = 1'b1;
        @(negedge clock);
        estouro_clr = 1'b0;
        #1;
        chk("pre_sat_estouro", estouro, 0);
        run_seg(1'b1, 5);
        run_seg(1'b0, 4000);
        #1;
        chk("sat_early_estouro", estouro, 0);
        run_seg(1'b0, 1000);
        #1;
        chk("sat_estouro", estouro, 1);
        run_seg(1'b1, 5);
        run_seg(1'b0, 5);
        #1;
        check_outputs("sat", 4095, 5, 4095, 40950, 4095);
        chk("sat_estouro_hold", estouro, 1);

        // Clear alone drops the flag on the next cycle.
        estouro_clr = 1'b1;
        @(negedge clock);
        estouro_clr = 1'b0;
        #1;
        chk("clr_estouro", estouro, 0);

        // Clear held through a saturation: set wins for exactly one cycle.
        estouro_clr = 1'b1;
        #1 est_cnt = 0;
        run_seg(1'b1, 4200);
        run_seg(1'b0, 5);
        estouro_clr = 1'b0;
        #1;
        chk("setwins_pulses", est_cnt, 1);
        chk("setwins_final", estouro, 0);
        period_3_4(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
